// File: rtl/pilot_pkg.sv
// Shared definitions for the pilot round-robin grant sequencer.
// Holds the sequencer state encoding and the fault-code constants.
// No ports; imported by pilot_arb_seq.
package pilot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_RETRY = 2'b01;
  localparam logic [1:0] FC_WDOG  = 2'b10;

endpackage

// File: rtl/pilot_rr_arb.sv
// Round-robin find-first-set: picks the first set req bit at or above ptr, wrapping at NCH.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: req (NCH request bits), ptr (search start) -> valid (any request), idx (chosen channel).
module pilot_rr_arb #(
  parameter int NCH  = 4,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic            valid,
  output logic [CH_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      int               c;
      logic [CH_W-1:0]  cidx;
      // ptr is always < NCH, so a single subtraction performs the wrap.
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      cidx = CH_W'(c);
      if (!valid && req[cidx]) begin
        valid = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/pilot_arb_seq.sv
// Round-robin grant sequencer over NCH channels with bounded nak retries and sticky fault.
// Latency: en->SCAN 1 cycle, grant 1 cycle later; ack->done/gnt drop 1 cycle; all outputs registered.
// Backpressure: a granted channel holds the sequencer until ack/nak (or watchdog expiry when
// PILOT_WDOG_EN is defined); naks back off BACKOFF_CYC cycles before re-granting the same channel.
// Ports: clk/rst (sync, active-high), en/clr from supervisor, req/ack/nak from channels;
// gnt/ch_id/busy/done/retry_cnt/fault/fault_code outputs.
module pilot_arb_seq
  import pilot_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CH_W        = $clog2(NCH),
  parameter int LOOP_MAX    = 5,
  parameter int CNT_W       = 3,
  parameter int BACKOFF_CYC = 2,
  parameter int WDOG_CYC    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NCH-1:0]  req,
  input  logic            ack,
  input  logic            nak,
  input  logic            clr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] ch_id,
  output logic            busy,
  output logic            done,
  output logic [CNT_W-1:0] retry_cnt,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam int BO_W = (BACKOFF_CYC < 2) ? 1 : $clog2(BACKOFF_CYC + 1);
  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]  ch_id_q, ch_id_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic [BO_W-1:0]  boff_q, boff_d;

`ifdef PILOT_WDOG_EN
  localparam int WD_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0]  wd_q, wd_d;
`endif

  logic             arb_vld;
  logic [CH_W-1:0]  arb_idx;

  pilot_rr_arb #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .valid (arb_vld),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ch_id_d = ch_id_q;
    done_d  = 1'b0;
    retry_d = retry_q;
    fault_d = fault_q;
    code_d  = code_q;
    boff_d  = boff_q;
`ifdef PILOT_WDOG_EN
    // Zero unless we stay in HOLD, so every HOLD entry starts a fresh count.
    wd_d    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_SCAN;
      end

      ST_SCAN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (arb_vld) begin
          ch_id_d = arb_idx;
          gnt_d   = ONE_HOT0 << arb_idx;
          retry_d = '0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (ack) begin
          // ack beats a simultaneous nak.
          gnt_d   = '0;
          done_d  = 1'b1;
          retry_d = '0;
          ptr_d   = (ch_id_q == CH_W'(NCH - 1)) ? '0 : ch_id_q + CH_W'(1);
          state_d = en ? ST_SCAN : ST_IDLE;
        end else if (nak) begin
          gnt_d = '0;
          if (retry_q == CNT_W'(LOOP_MAX - 1)) begin
            retry_d = CNT_W'(LOOP_MAX);
            fault_d = 1'b1;
            code_d  = FC_RETRY;
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + CNT_W'(1);
            boff_d  = BO_W'(BACKOFF_CYC);
            state_d = ST_BACKOFF;
          end
        end else begin
`ifdef PILOT_WDOG_EN
          if (wd_q == WD_W'(WDOG_CYC - 1)) begin
            gnt_d   = '0;
            fault_d = 1'b1;
            code_d  = FC_WDOG;
            state_d = ST_FAULT;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
`endif
        end
      end

      ST_BACKOFF: begin
        // Counter reaches zero after BACKOFF_CYC cycles; the next edge re-grants.
        if (boff_q == '0) begin
          gnt_d   = ONE_HOT0 << ch_id_q;
          state_d = ST_HOLD;
        end else begin
          boff_d = boff_q - BO_W'(1);
        end
      end

      ST_FAULT: begin
        gnt_d = '0;
        if (clr) begin
          fault_d = 1'b0;
          code_d  = FC_NONE;
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ch_id_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      retry_q <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      boff_q  <= '0;
`ifdef PILOT_WDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ch_id_q <= ch_id_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      boff_q  <= boff_d;
`ifdef PILOT_WDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign ch_id      = ch_id_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign retry_cnt  = retry_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_pilot_arb_seq.sv
// Directed bench for pilot_arb_seq (NCH=4, LOOP_MAX=5, BACKOFF_CYC=2, WDOG_CYC=8).
// Expected grants are queued when requests are driven and popped when a grant appears.
// Watchdog steps are selected by PILOT_WDOG_EN, matching the design build.
module tb_pilot_arb_seq;

  localparam int NCH   = 4;
  localparam int CH_W  = 2;
  localparam int CNT_W = 3;
  localparam int BOFF  = 2;

  logic             clk = 1'b0;
  logic             rst, en, ack, nak, clr;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   gnt;
  logic [CH_W-1:0]  ch_id;
  logic             busy, done, fault;
  logic [CNT_W-1:0] retry_cnt;
  logic [1:0]       fault_code;

  int n_chk  = 0;
  int n_pass = 0;
  logic [NCH-1:0] exp_gnt_q[$];

  always #5 clk = ~clk;

  pilot_arb_seq #(
    .NCH(NCH), .CH_W(CH_W), .LOOP_MAX(5), .CNT_W(CNT_W),
    .BACKOFF_CYC(BOFF), .WDOG_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack), .nak(nak), .clr(clr),
    .gnt(gnt), .ch_id(ch_id), .busy(busy), .done(done),
    .retry_cnt(retry_cnt), .fault(fault), .fault_code(fault_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a grant, then compares it against the scoreboard head.
  task automatic wait_gnt(input string tag);
    logic [NCH-1:0] e;
    int cyc;
    cyc = 0;
    while (gnt == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_gnt_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s: grant %0h observed with empty scoreboard", tag, gnt);
    end else begin
      e = exp_gnt_q.pop_front();
      chk(tag, 32'(gnt), 32'(e));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0; nak = 1'b0; clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_chid",  32'(ch_id), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code",  32'(fault_code), 32'd0);

    // Round-robin fairness, then sparse request set with wrap from channel 3 to 0.
    req = 4'b1111;
    en  = 1'b1;
    exp_gnt_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b0010);
    exp_gnt_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b1000);
    exp_gnt_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b1000);
    exp_gnt_q.push_back(4'b0001);
    tick(1);
    chk("scan_no_gnt", 32'(gnt), 32'd0);
    chk("scan_busy",   32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_gnt($sformatf("rr_gnt%0d", i));
      ack = 1'b1;
      if (i == 4) req = 4'b1001;
      tick(1);
      ack = 1'b0;
      chk($sformatf("rr_done%0d", i), 32'(done), 32'd1);
      chk($sformatf("rr_gnt_low%0d", i), 32'(gnt), 32'd0);
      tick(1);
      chk($sformatf("rr_done_low%0d", i), 32'(done), 32'd0);
    end
    wait_gnt("wrap_ch3");
    chk("wrap_chid3", 32'(ch_id), 32'd3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("wrap_done3", 32'(done), 32'd1);
    tick(1);
    wait_gnt("wrap_ch0");
    chk("wrap_chid0", 32'(ch_id), 32'd0);
    ack = 1'b1; en = 1'b0; req = '0;
    tick(1);
    ack = 1'b0;
    chk("idle_done", 32'(done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Retry limit: pointer now 1, channel 1 naks every grant.
    req = 4'b0010;
    en  = 1'b1;
    exp_gnt_q.push_back(4'b0010);
    tick(1);
    wait_gnt("retry_first");
    for (int k = 1; k <= 4; k++) begin
      nak = 1'b1;
      tick(1);
      nak = 1'b0;
      chk($sformatf("nak_gnt_low%0d", k), 32'(gnt), 32'd0);
      chk($sformatf("nak_retry%0d", k), 32'(retry_cnt), 32'(k));
      tick(BOFF);
      chk($sformatf("backoff_gap%0d", k), 32'(gnt), 32'd0);
      tick(1);
      chk($sformatf("regrant%0d", k), 32'(gnt), 32'(4'b0010));
    end
    nak = 1'b1;
    tick(1);
    nak = 1'b0;
    chk("lim_fault", 32'(fault), 32'd1);
    chk("lim_code",  32'(fault_code), 32'd1);
    chk("lim_retry", 32'(retry_cnt), 32'd5);
    chk("lim_gnt",   32'(gnt), 32'd0);
    chk("lim_busy",  32'(busy), 32'd0);
    tick(3);
    chk("fault_sticky", 32'(fault), 32'd1);
    en  = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code",  32'(fault_code), 32'd0);
    chk("clr_retry", 32'(retry_cnt), 32'd0);
    chk("clr_busy",  32'(busy), 32'd0);

    // ack and nak together: ack wins, retry count clears, no backoff.
    req = 4'b0100;
    en  = 1'b1;
    exp_gnt_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b0100);
    tick(1);
    wait_gnt("an_gnt");
    nak = 1'b1;
    tick(1);
    nak = 1'b0;
    chk("an_retry1", 32'(retry_cnt), 32'd1);
    tick(BOFF);
    wait_gnt("an_regrant");
    ack = 1'b1; nak = 1'b1;
    tick(1);
    ack = 1'b0; nak = 1'b0;
    chk("an_done",  32'(done), 32'd1);
    chk("an_retry", 32'(retry_cnt), 32'd0);
    chk("an_gnt_low", 32'(gnt), 32'd0);
    tick(1);
    chk("an_no_backoff", 32'(gnt), 32'(4'b0100));

    // Reset while channel 2 holds the grant.
    rst = 1'b1;
    req = 4'b1111;
    tick(1);
    chk("mrst_gnt",   32'(gnt), 32'd0);
    chk("mrst_done",  32'(done), 32'd0);
    chk("mrst_busy",  32'(busy), 32'd0);
    chk("mrst_chid",  32'(ch_id), 32'd0);
    chk("mrst_retry", 32'(retry_cnt), 32'd0);
    rst = 1'b0;
    exp_gnt_q.push_back(4'b0001);
    tick(1);
    wait_gnt("mrst_ptr0");

`ifdef PILOT_WDOG_EN
    tick(7);
    chk("wd_pre_gnt",   32'(gnt), 32'(4'b0001));
    chk("wd_pre_fault", 32'(fault), 32'd0);
    tick(1);
    chk("wd_fault", 32'(fault), 32'd1);
    chk("wd_code",  32'(fault_code), 32'd2);
    chk("wd_gnt",   32'(gnt), 32'd0);
    en  = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    en  = 1'b1;
    exp_gnt_q.push_back(4'b0001);
    tick(1);
    wait_gnt("wd_ack_gnt");
    tick(7);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("wd_ack_done",  32'(done), 32'd1);
    chk("wd_ack_fault", 32'(fault), 32'd0);
`else
    tick(70);
    chk("hold_gnt",   32'(gnt), 32'(4'b0001));
    chk("hold_fault", 32'(fault), 32'd0);
    chk("hold_code",  32'(fault_code), 32'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("hold_done", 32'(done), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pilot_arb_seq.md
# pilot_arb_seq

Parametrised successor to the single-channel pilot controller. It is a round-robin grant sequencer serving NCH requesting channels. Each transaction is bounded: a channel may nak it at most LOOP_MAX times before the sequencer locks into a sticky fault, and an optional watchdog bounds the hold time. It sits between the channel request/ack fabric and the supervisory controller, which drives `en` and `clr`.

## Interface
- NCH, 4: number of requesting channels (2..16)
- CH_W, $clog2(NCH): channel index width
- LOOP_MAX, 5: naks allowed per transaction; the LOOP_MAX-th nak faults (1..2^CNT_W-1)
- CNT_W, 3: retry counter width
- BACKOFF_CYC, 2: idle cycles between nak and re-grant (≥1)
- WDOG_CYC, 64: HOLD timeout, only used with the watchdog macro

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sequencer enable
- req  in  NCH  per-channel request level
- ack  in  1  granted channel completed
- nak  in  1  granted channel rejected; retry
- clr  in  1  clear fault
- gnt  out  NCH  one-hot grant, registered
- ch_id  out  CH_W  index of current/last granted channel
- busy  out  1  state ≠ IDLE and ≠ FAULT
- done  out  1  one-cycle completion pulse
- retry_cnt  out  CNT_W  naks on current transaction
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 retry limit, 10 watchdog

## Operation
- States: IDLE, SCAN, HOLD, BACKOFF, FAULT. All outputs are registered.
- Reset: state IDLE; rr pointer 0; gnt 0, ch_id 0, busy 0, done 0, retry_cnt 0, fault 0, fault_code 00.
- IDLE: en=1 → SCAN.
- SCAN:
  - en=0 → IDLE.
  - req==0 → stay in SCAN.
  - Otherwise select the first set req bit at or above the pointer, wrapping at NCH. Latch ch_id, set gnt[ch_id] → HOLD.
- HOLD:
  - ack → gnt 0, done=1 for one cycle, retry_cnt 0, pointer = (ch_id+1) mod NCH. Then → SCAN if en=1, else → IDLE.
  - nak with retry_cnt == LOOP_MAX-1 → gnt 0, retry_cnt = LOOP_MAX, fault 1, code 01 → FAULT.
  - Any other nak → retry_cnt+1, gnt 0, backoff counter loaded → BACKOFF.
  - ack and nak in the same cycle: ack wins.
  - Neither → hold gnt.
  - A req drop while in HOLD is ignored; the transaction completes only via ack, nak or fault.
- BACKOFF: after BACKOFF_CYC cycles, re-assert gnt for the same ch_id → HOLD. There is no re-arbitration. en is ignored here.
- FAULT: gnt 0; fault and fault_code hold. clr=1 → IDLE, clearing fault, fault_code and retry_cnt. The pointer is retained.
- clr outside FAULT has no effect.

## Timing
- en sampled high at edge N, req already set: SCAN after N, gnt high after N+1.
- ack sampled at edge M: gnt low and done high after M. done is low again after M+1.
- First-transaction nak at edge M: gnt low after M, high again after M+BACKOFF_CYC+1.
- rst mid-transaction: gnt drops on the reset edge, with no done pulse.
- Pointer wrap: with ch_id = NCH-1, the next search starts at 0.

## Configuration
- PILOT_WDOG_EN defined:
  - A cycle counter runs in HOLD. It is cleared on every HOLD entry, including re-entry from BACKOFF.
  - If WDOG_CYC consecutive HOLD cycles pass without ack or nak → gnt 0, fault 1, code 10 → FAULT.
  - ack or nak on the expiry cycle takes priority over the timeout.
- PILOT_WDOG_EN undefined: no watchdog counter exists, HOLD waits indefinitely, and code 10 is never produced.

## Structure
- Shared package pilot_pkg holds:
  - the state enum
  - the fault-code constants FC_NONE, FC_RETRY, FC_WDOG
- One sub-module, pilot_rr_arb: combinational round-robin find-first-set. Inputs req and ptr; outputs valid and idx.
- The top level owns the FSM, the retry, backoff and watchdog counters, and the output registers.

## Test plan
- Round-robin fairness: NCH=4, en=1, req=4'b1111, ack one cycle after each grant → gnt sequence 0001, 0010, 0100, 1000, 0001, with done pulsed each time.
- Sparse and wrap: req=4'b1001, pointer at 1 → grant channel 3, then channel 0.
- Retry limit: LOOP_MAX=5, nak on every grant → 4 backoffs of 2 cycles each. The 5th nak gives fault=1, code 01, retry_cnt=5. clr → IDLE with fault 0.
- Simultaneous ack+nak in HOLD → treated as ack: done=1, retry_cnt=0, no BACKOFF.
- Watchdog (PILOT_WDOG_EN, WDOG_CYC=8): grant with no response for 8 cycles → code 10. In a separate run, an ack on cycle 8 → normal completion.
- Reset mid-HOLD: rst=1 while gnt=4'b0100 → all outputs 0 next edge, state IDLE, pointer 0.
